// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.hh BCD stopwatch.
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam bcd_t HUND_MAX     = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DEC_MAX      = 4'd9;
  localparam int   NUM_DIGITS   = 6;
endpackage

// File: rtl/stopwatch_bcd_counter_digit_cnt.sv
// One BCD digit that wraps at MAX; carry is combinational so a full ripple
// through all digits settles within a single clock.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DEC_MAX
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry
);
  bcd_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr)      digit_d = '0;
    else if (inc) digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) digit_q <= '0;
    else        digit_q <= digit_d;

  assign digit = digit_q;
  assign carry = inc & (digit_q == MAX);
endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch run/pause/clear FSM plus six-digit BCD chain (MM:SS.hh).
// Optional lap display freeze is compiled in with STOPWATCH_LAP_EN.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_TENS_MAX    = 5,
  parameter int LAP_HOLD_CYCLES = 0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic hundredth_of_second_passed,
  input  logic start_stop,
  input  logic clear,
`ifdef STOPWATCH_LAP_EN
  input  logic lap,
  output logic lap_active,
`endif
  output logic device_running,
  output bcd_t hund_ones,
  output bcd_t hund_tens,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic overflow
);
  if (LAP_HOLD_CYCLES != 0) begin : g_lap_hold_reserved
    $error("LAP_HOLD_CYCLES is reserved and must be 0");
  end

  state_e state_q, state_d;
  logic   overflow_q, overflow_d;
  logic   run_tick, clr_cnt;
  bcd_t [NUM_DIGITS-1:0] live, disp;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_stop && !clear) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSE;
      PAUSE:   if (clear) state_d = IDLE;
               else if (start_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counting keys off the registered state, so a tick coinciding with
  // RUN->PAUSE still counts and one coinciding with PAUSE->RUN does not.
  assign run_tick = (state_q == RUN) && hundredth_of_second_passed;
  assign clr_cnt  = clear && (state_q != RUN);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    localparam bcd_t DMAX = (g == 5) ? bcd_t'(MIN_TENS_MAX) :
                            (g == 3) ? SEC_TENS_MAX :
                            (g < 2)  ? HUND_MAX : DEC_MAX;
    logic inc, carry;
    if (g == 0) begin : g_first
      assign inc = run_tick;
    end else begin : g_next
      assign inc = g_dig[g-1].carry;
    end
    bcd_digit_cnt #(.MAX(DMAX)) u_digit (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (clr_cnt),
      .inc   (inc),
      .digit (live[g]),
      .carry (carry)
    );
  end

  assign overflow_d = g_dig[NUM_DIGITS-1].carry;

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end

`ifdef STOPWATCH_LAP_EN
  logic frozen_q, frozen_d;
  bcd_t [NUM_DIGITS-1:0] snap_q, snap_d;

  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (state_q == RUN && lap) begin
      frozen_d = !frozen_q;
      if (!frozen_q) snap_d = live;
    end
    if ((state_q == RUN && start_stop) || clear) frozen_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end

  assign disp       = frozen_q ? snap_q : live;
  assign lap_active = frozen_q;
`else
  assign disp = live;
`endif

  assign device_running = (state_q == RUN);
  assign overflow       = overflow_q;
  assign hund_ones      = disp[0];
  assign hund_tens      = disp[1];
  assign sec_ones       = disp[2];
  assign sec_tens       = disp[3];
  assign min_ones       = disp[4];
  assign min_tens       = disp[5];
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter; minutes-tens max set to 0 so the
// full wrap (09:59.99 -> 00:00.00) fits in a short run.
module tb_stopwatch_bcd_counter;
  logic CLK = 1'b0, RESET = 1'b0;
  logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic device_running, overflow;
  logic [3:0] hund_ones, hund_tens, sec_ones, sec_tens, min_ones, min_tens;
`ifdef STOPWATCH_LAP_EN
  logic lap = 1'b0, lap_active;
`endif
  int total = 0, fails = 0, ovf_cnt = 0;
  logic [23:0] digits;

  assign digits = {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones};

  always #5 CLK = ~CLK;

  stopwatch_bcd_counter #(.MIN_TENS_MAX(0), .LAP_HOLD_CYCLES(0)) dut (
    .CLK(CLK), .RESET(RESET),
    .hundredth_of_second_passed(tick),
    .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap), .lap_active(lap_active),
`endif
    .device_running(device_running),
    .hund_ones(hund_ones), .hund_tens(hund_tens),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds tick high for n cycles, counting any overflow pulse seen.
  task automatic run_ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      if (overflow) ovf_cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic pulse(input logic t, input logic ss, input logic cl);
    tick = t; start_stop = ss; clear = cl;
    @(posedge CLK); #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_digits", digits, 24'h000000);
    chk("rst_running", device_running, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    @(posedge CLK); #1; RESET = 1'b1;
    @(posedge CLK); #1;

    pulse(0, 1, 0);
    chk("start_running", device_running, 1'b1);
    run_ticks(100);
    chk("100_ticks", digits, 24'h000100);
    chk("100_running", device_running, 1'b1);

    run_ticks(5899);
    chk("at_005999", digits, 24'h005999);
    run_ticks(1);
    chk("ripple_to_min", digits, 24'h010000);

    run_ticks(53999);
    chk("at_095999", digits, 24'h095999);
    chk("no_early_ovf", ovf_cnt, 0);
    run_ticks(1);
    chk("wrap_digits", digits, 24'h000000);
    chk("wrap_overflow", overflow, 1'b1);
    chk("wrap_running", device_running, 1'b1);
    @(posedge CLK); #1;
    chk("ovf_one_cycle", overflow, 1'b0);
    chk("wrap_hold", digits, 24'h000000);

    run_ticks(5);
    pulse(1, 1, 0);
    chk("tick_with_stop", digits, 24'h000006);
    chk("paused", device_running, 1'b0);
    run_ticks(10);
    chk("pause_holds", digits, 24'h000006);
    pulse(1, 1, 0);
    chk("resume_tick_dropped", digits, 24'h000006);
    chk("resumed", device_running, 1'b1);

    pulse(0, 1, 1);
    chk("run_ss_wins", device_running, 1'b0);
    chk("run_ss_clr_hold", digits, 24'h000006);
    pulse(0, 0, 1);
    chk("pause_clear", digits, 24'h000000);
    chk("pause_clear_idle", device_running, 1'b0);

    pulse(0, 1, 0);
    run_ticks(327);
    pulse(0, 1, 0);
    chk("paused_0327", digits, 24'h000327);
    pulse(0, 1, 1);
    chk("clear_wins_digits", digits, 24'h000000);
    chk("clear_wins_idle", device_running, 1'b0);
    pulse(0, 1, 1);
    chk("idle_clear_wins", device_running, 1'b0);
    pulse(0, 0, 1);
    chk("idle_clear_noop", digits, 24'h000000);

    pulse(0, 1, 0);
    run_ticks(3);
    pulse(0, 0, 1);
    chk("run_clear_ignored", digits, 24'h000003);
    chk("run_clear_running", device_running, 1'b1);

    run_ticks(9453);
    chk("at_013456", digits, 24'h013456);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_digits", digits, 24'h000000);
    chk("async_rst_idle", device_running, 1'b0);
    @(posedge CLK); #1; RESET = 1'b1;
    @(posedge CLK); #1;

`ifdef STOPWATCH_LAP_EN
    chk("lap_rst", lap_active, 1'b0);
    pulse(0, 1, 0);
    run_ticks(100);
    lap = 1'b1; @(posedge CLK); #1; lap = 1'b0;
    chk("lap_active", lap_active, 1'b1);
    run_ticks(50);
    chk("lap_frozen", digits, 24'h000100);
    lap = 1'b1; @(posedge CLK); #1; lap = 1'b0;
    chk("lap_release", digits, 24'h000150);
    chk("lap_inactive", lap_active, 1'b0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Downstream consumer of the 1/100 s tick generator; accumulates elapsed time as BCD digits MM:SS.hh for the 7-segment display driver.
- Owns the run/pause/clear control FSM and drives `device_running` back to the tick generator, which gates its prescaler on it.
- Control inputs are single-cycle pulses from the upstream button debouncer.

Parameters:
- MIN_TENS_MAX, 5, highest value of minutes-tens digit (range 00–59 minutes).
- LAP_HOLD_CYCLES, 0, reserved for future use; must stay 0, has no effect.

Ports:
- CLK  in  1  system clock, 27 MHz.
- RESET  in  1  asynchronous active-low reset.
- hundredth_of_second_passed  in  1  1-cycle tick from the tick generator.
- start_stop  in  1  1-cycle pulse; toggles run/pause.
- clear  in  1  1-cycle pulse; zeroes the count when not running.
- device_running  out  1  high while in RUN; goes to the tick generator.
- hund_ones, hund_tens  out  4 each  BCD hundredths digits.
- sec_ones, sec_tens  out  4 each  BCD seconds digits (tens 0–5).
- min_ones, min_tens  out  4 each  BCD minutes digits (tens 0–MIN_TENS_MAX).
- overflow  out  1  1-cycle pulse when the count wraps from max to zero.

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE, all digits 0, device_running=0, overflow=0.
  - Released synchronously on the next CLK edge.
- FSM states: IDLE (count zero, stopped), RUN, PAUSE (count held). State is registered; device_running is decoded combinationally from state (RUN → 1).
- Transitions, evaluated at the CLK edge:
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN.
  - PAUSE + clear → IDLE, digits zeroed in the same edge.
  - IDLE + clear → stay IDLE (no-op).
  - RUN + clear → ignored.
- Simultaneous start_stop and clear:
  - IDLE or PAUSE: clear wins.
  - RUN: start_stop wins, clear is dropped.
- Counting:
  - Digits advance only when the registered state is RUN and the tick is high.
  - A tick in the same cycle as a RUN→PAUSE pulse is still counted.
  - A tick in the same cycle as a PAUSE→RUN pulse is not counted.
  - Latency: digits update on the CLK edge that samples the tick. No pipelining.
- Carry chain, all digits updated in one edge:
  - hund_ones 9→0 carries into hund_tens.
  - hund_tens 9→0 carries into sec_ones.
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - min_tens MIN_TENS_MAX→0 is the terminal carry.
- Wrap: at MIN_TENS_MAX9:59.99 plus one tick, all digits go to 0, overflow pulses high for exactly one cycle, and state stays RUN.
- No digit ever holds a non-BCD value or exceeds its maximum.
- Reset mid-count: all outputs go to reset values immediately (asynchronously), regardless of state.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Extra input lap (1-cycle pulse) and output lap_active.
  - In RUN, lap toggles a display-freeze register.
  - While frozen, the digit outputs present a snapshot latched at the lap edge; internal counting continues.
  - A second lap pulse, a start_stop into PAUSE, or a clear releases the freeze.
  - lap_active=1 while frozen; reset value 0.
- Not defined: no lap port, no snapshot registers; digit outputs always reflect the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - State encoding constants IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Digit maxima: HUND_MAX=9, SEC_TENS_MAX=5, DEC_MAX=9.
  - The 4-bit BCD digit typedef.
- Sub-module bcd_digit_cnt, instantiated six times:
  - Parameter MAX.
  - Inputs: CLK, RESET, clr, inc.
  - Outputs: digit[3:0], and carry = inc & (digit==MAX), which is combinational.

Test Plan:
- Reset, then start_stop, then 100 ticks → hund=00, sec_ones=1, device_running=1, overflow never asserted.
- Count to 00:59.99, one tick → min_ones=1, all other digits 0, carry ripples in a single edge.
- Preload near max (run 359999 ticks) to 59:59.99, one more tick → all digits 0, overflow high for exactly 1 cycle, state RUN.
- RUN, tick and start_stop in the same cycle → count +1, state PAUSE; 10 further ticks → digits unchanged.
- PAUSE at 00:03.27, clear and start_stop in the same cycle → IDLE, all digits 0, device_running=0; in RUN, clear alone → ignored, count unchanged.
- Assert RESET mid-count at 12:34.56 → all digits 0, IDLE, without waiting for a CLK edge; with STOPWATCH_LAP_EN, lap at 00:01.00, then 50 ticks → outputs frozen at 00:01.00, second lap → 00:01.50.
